// File: rtl/psum_deskew_writer.sv
// Drain stage for the systolic array: deskews staggered column partial sums into rows,
// applies optional ReLU plus OW-bit saturation, and writes one row per cycle to the output buffer.
module psum_deskew_writer #(
    parameter int unsigned N    = 16,
    parameter int unsigned DW   = 32,
    parameter int unsigned OW   = 16,
    parameter int unsigned AW   = 13,
    parameter int unsigned ROWS = 16
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    input  logic [AW-1:0]   OBASE,
    input  logic            RELU_EN,
    input  logic            PSUM_VALID,
    input  logic [N*DW-1:0] PSUM,
    output logic            out_cen,
    output logic            out_wen,
    output logic [AW-1:0]   out_addr,
    output logic [N*OW-1:0] out_wdata,
    output logic            BUSY,
    output logic            DONE,
    output logic            ERR
);
    localparam int unsigned CW = $clog2(ROWS + 1);
    localparam logic [CW-1:0] ROWS_C = CW'(ROWS);

    typedef enum logic [1:0] {IDLE, ARMED, DRAIN, DONE_ST} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   obase_q, obase_d;
    logic            relu_q, relu_d;
    logic [CW-1:0]   acc_cnt_q, acc_cnt_d;
    logic [CW-1:0]   wr_cnt_q, wr_cnt_d;
    logic            err_q, err_d;
    logic [N-2:0]    vld_q, vld_d;
    logic            wr_n_q, wr_n_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [N*OW-1:0] wdata_q, wdata_d;
    logic [N*DW-1:0] aligned;
    logic            accept;
    logic            wr_fire;

    function automatic logic [OW-1:0] post_proc(input logic [DW-1:0] x, input logic relu);
        logic [DW-1:0] y;
        y = (relu && x[DW-1]) ? '0 : x;
        // Fits in OW bits exactly when every bit from OW-1 upward equals the sign.
        if ((&y[DW-1:OW-1]) || !(|y[DW-1:OW-1]))
            return y[OW-1:0];
        return y[DW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    endfunction

    for (genvar k = 0; k < N; k++) begin : g_lane
        if (k == N - 1) begin : g_pass
            assign aligned[k*DW +: DW] = PSUM[k*DW +: DW];
        end else begin : g_dly
            localparam int unsigned D = N - 1 - k;
            logic [DW-1:0] sr_q [D];
            logic [DW-1:0] sr_d [D];

            always_comb begin
                sr_d[0] = PSUM[k*DW +: DW];
                for (int unsigned j = 1; j < D; j++)
                    sr_d[j] = sr_q[j-1];
            end

            always_ff @(posedge CLK or negedge RESET) begin
                if (!RESET) begin
                    for (int unsigned j = 0; j < D; j++)
                        sr_q[j] <= '0;
                end else begin
                    sr_q <= sr_d;
                end
            end

            assign aligned[k*DW +: DW] = sr_q[D-1];
        end
    end

    always_comb begin
        state_d   = state_q;
        obase_d   = obase_q;
        relu_d    = relu_q;
        acc_cnt_d = acc_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        err_d     = err_q;
        wr_n_d    = 1'b1;
        addr_d    = addr_q;
        wdata_d   = wdata_q;

        accept  = PSUM_VALID && ((state_q == ARMED) ||
                                 ((state_q == DRAIN) && (acc_cnt_q < ROWS_C)));
        wr_fire = vld_q[N-2];

        if (PSUM_VALID && !accept)
            err_d = 1'b1;
        if (accept)
            acc_cnt_d = acc_cnt_q + 1'b1;

        vld_d[0] = accept;
        for (int unsigned j = 1; j < N - 1; j++)
            vld_d[j] = vld_q[j-1];

        if (wr_fire) begin
            wr_n_d   = 1'b0;
            addr_d   = obase_q + AW'(wr_cnt_q);
            wr_cnt_d = wr_cnt_q + 1'b1;
            for (int unsigned k = 0; k < N; k++)
                wdata_d[k*OW +: OW] = post_proc(aligned[k*DW +: DW], relu_q);
        end

        // wr_cnt reaches ROWS while the last write is on the bus, so DONE_ST follows it.
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    state_d   = ARMED;
                    obase_d   = OBASE;
                    relu_d    = RELU_EN;
                    acc_cnt_d = '0;
                    wr_cnt_d  = '0;
                end
            end
            ARMED:   if (accept) state_d = DRAIN;
            DRAIN:   if (wr_cnt_q == ROWS_C) state_d = DONE_ST;
            DONE_ST: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= IDLE;
            obase_q   <= '0;
            relu_q    <= 1'b0;
            acc_cnt_q <= '0;
            wr_cnt_q  <= '0;
            err_q     <= 1'b0;
            vld_q     <= '0;
            wr_n_q    <= 1'b1;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            obase_q   <= obase_d;
            relu_q    <= relu_d;
            acc_cnt_q <= acc_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_q     <= err_d;
            vld_q     <= vld_d;
            wr_n_q    <= wr_n_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign out_cen   = wr_n_q;
    assign out_wen   = wr_n_q;
    assign out_addr  = addr_q;
    assign out_wdata = wdata_q;
    assign BUSY      = (state_q == ARMED) || (state_q == DRAIN);
    assign DONE      = (state_q == DONE_ST);
    assign ERR       = err_q;

endmodule

// File: tb/tb_psum_deskew_writer.sv
// Directed bench for psum_deskew_writer: skewed row injection, write capture, and
// immediate-assertion checks against hand-computed rows, addresses and timing.
module tb_psum_deskew_writer;
    localparam int N  = 16;
    localparam int DW = 32;
    localparam int OW = 16;
    localparam int AW = 13;

    logic            CLK = 1'b0;
    logic            RESET;
    logic            START;
    logic [AW-1:0]   OBASE;
    logic            RELU_EN;
    logic            PSUM_VALID;
    logic [N*DW-1:0] PSUM;
    logic            out_cen;
    logic            out_wen;
    logic [AW-1:0]   out_addr;
    logic [N*OW-1:0] out_wdata;
    logic            BUSY;
    logic            DONE;
    logic            ERR;

    psum_deskew_writer #(.N(N), .DW(DW), .OW(OW), .AW(AW), .ROWS(16)) dut (
        .CLK(CLK), .RESET(RESET), .START(START), .OBASE(OBASE), .RELU_EN(RELU_EN),
        .PSUM_VALID(PSUM_VALID), .PSUM(PSUM), .out_cen(out_cen), .out_wen(out_wen),
        .out_addr(out_addr), .out_wdata(out_wdata), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    int n_chk = 0;
    int n_fail = 0;

    int cyc = 0;
    int nw = 0;
    int done_n = 0;
    int done_cyc = 0;
    int bus_bad = 0;
    logic [AW-1:0]   wr_addr [512];
    logic [N*OW-1:0] wr_data [512];
    int              wr_cyc  [512];

    int              nrows;
    int              st  [32];
    logic [DW-1:0]   rd  [32][16];
    logic [N*OW-1:0] expw [32];
    int              vcyc0;
    int              nw_base;
    int              done_base;
    logic            busy_mid;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (out_cen !== out_wen) bus_bad++;
        if (out_cen === 1'b0 && nw < 512) begin
            wr_addr[nw] = out_addr;
            wr_data[nw] = out_wdata;
            wr_cyc[nw]  = cyc;
            nw++;
        end
        if (DONE === 1'b1) begin
            done_n++;
            done_cyc = cyc;
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic fill_std(input int off);
        nrows = 16;
        for (int r = 0; r < 16; r++) begin
            st[r] = r;
            for (int k = 0; k < N; k++) begin
                rd[r][k] = 32'(r*16 + k + off);
                expw[r][k*OW +: OW] = 16'(r*16 + k + off);
            end
        end
    endtask

    task automatic start_job(input logic [AW-1:0] ob, input logic re);
        START = 1'b1;
        OBASE = ob;
        RELU_EN = re;
        @(posedge CLK); #1;
        START = 1'b0;
        RELU_EN = ~re;
        nw_base = nw;
        done_base = done_n;
        chk("busy_after_start", 256'(BUSY), 256'd1);
    endtask

    task automatic drive(input int abort_w, input int mid_c);
        int last;
        last = st[nrows-1] + N + 3;
        for (int c = 0; c <= last; c++) begin
            PSUM_VALID = 1'b0;
            for (int k = 0; k < N; k++) PSUM[k*DW +: DW] = 32'h0000_0BAD;
            for (int r = 0; r < nrows; r++) begin
                if (st[r] == c) begin
                    PSUM_VALID = 1'b1;
                    if (r == 0) vcyc0 = cyc;
                end
                for (int k = 0; k < N; k++)
                    if (st[r] == c - k) PSUM[k*DW +: DW] = rd[r][k];
            end
            START = (c == mid_c);
            if (c == mid_c) OBASE = 13'h0AAA;
            @(posedge CLK); #1;
            if (c == mid_c) busy_mid = BUSY;
            START = 1'b0;
            if (abort_w >= 0 && (nw - nw_base) >= abort_w) begin
                RESET = 1'b0;
                break;
            end
        end
        PSUM_VALID = 1'b0;
        START = 1'b0;
    endtask

    task automatic check_job(input string tag, input logic [AW-1:0] base);
        int i;
        chk({tag, "_nwr"}, 256'(nw - nw_base), 256'd16);
        for (int r = 0; r < 16; r++) begin
            i = nw_base + r;
            chk($sformatf("%s_addr%0d", tag, r), 256'(wr_addr[i]), 256'(13'(base + 13'(r))));
            chk($sformatf("%s_data%0d", tag, r), 256'(wr_data[i]), 256'(expw[r]));
            chk($sformatf("%s_cyc%0d", tag, r), 256'(wr_cyc[i]), 256'(vcyc0 + N + st[r]));
        end
        chk({tag, "_done_cnt"}, 256'(done_n - done_base), 256'd1);
        chk({tag, "_done_cyc"}, 256'(done_cyc), 256'(wr_cyc[nw_base + 15] + 1));
        chk({tag, "_busy_end"}, 256'(BUSY), 256'd0);
    endtask

    initial begin
        RESET = 1'b0;
        START = 1'b0;
        OBASE = '0;
        RELU_EN = 1'b0;
        PSUM_VALID = 1'b0;
        PSUM = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_cen",   256'(out_cen),   256'd1);
        chk("rst_wen",   256'(out_wen),   256'd1);
        chk("rst_addr",  256'(out_addr),  256'd0);
        chk("rst_wdata", 256'(out_wdata), 256'd0);
        chk("rst_busy",  256'(BUSY),      256'd0);
        chk("rst_done",  256'(DONE),      256'd0);
        chk("rst_err",   256'(ERR),       256'd0);
        @(negedge CLK) RESET = 1'b1;
        @(posedge CLK); #1;

        // T1 basic back-to-back rows
        fill_std(0);
        start_job(13'h0100, 1'b0);
        drive(-1, -1);
        check_job("t1", 13'h0100);
        chk("t1_err", 256'(ERR), 256'd0);
        chk("t1_bus", 256'(bus_bad), 256'd0);

        // T2 saturation, ReLU off
        fill_std(0);
        rd[0][0] = 32'h0001_0000; expw[0][0*OW +: OW] = 16'h7FFF;
        rd[0][1] = 32'hFFFF_0000; expw[0][1*OW +: OW] = 16'h8000;
        rd[0][2] = 32'h0000_7FFF; expw[0][2*OW +: OW] = 16'h7FFF;
        rd[0][3] = 32'hFFFF_8000; expw[0][3*OW +: OW] = 16'h8000;
        rd[0][4] = 32'hFFFF_7FFF; expw[0][4*OW +: OW] = 16'h8000;
        rd[0][5] = 32'h0000_8000; expw[0][5*OW +: OW] = 16'h7FFF;
        rd[0][6] = 32'hFFFF_FFFB; expw[0][6*OW +: OW] = 16'hFFFB;
        start_job(13'h0200, 1'b0);
        drive(-1, -1);
        check_job("t2", 13'h0200);

        // T3 ReLU on
        fill_std(0);
        rd[0][0] = 32'hFFFF_FFFB; expw[0][0*OW +: OW] = 16'h0000;
        rd[0][1] = 32'h0000_0007; expw[0][1*OW +: OW] = 16'h0007;
        rd[0][2] = 32'h8000_0000; expw[0][2*OW +: OW] = 16'h0000;
        rd[0][3] = 32'h7FFF_FFFF; expw[0][3*OW +: OW] = 16'h7FFF;
        start_job(13'h0300, 1'b1);
        drive(-1, -1);
        check_job("t3", 13'h0300);
        chk("t3_err", 256'(ERR), 256'd0);

        // T4 gaps of 0..3 cycles, then a 17th valid that must be dropped
        fill_std(16'h0100);
        for (int r = 1; r < 16; r++) st[r] = st[r-1] + 1 + (r % 4);
        nrows = 17;
        st[16] = st[15] + 1;
        for (int k = 0; k < N; k++) rd[16][k] = 32'h0000_7777;
        start_job(13'h0400, 1'b0);
        drive(-1, -1);
        check_job("t4", 13'h0400);
        chk("t4_err", 256'(ERR), 256'd1);

        // T5 address wrap and ignored mid-job START
        fill_std(16'h0500);
        start_job(13'h1FF8, 1'b0);
        drive(-1, 5);
        check_job("t5", 13'h1FF8);
        chk("t5_wrap_addr8", 256'(wr_addr[nw_base + 8]), 256'h0);
        chk("t5_busy_mid", 256'(busy_mid), 256'd1);

        // T6 reset after the 5th write, then a clean job
        fill_std(16'h2000);
        start_job(13'h0600, 1'b0);
        drive(5, -1);
        #1;
        chk("t6_nwr_abort", 256'(nw - nw_base), 256'd5);
        chk("t6_addr4",  256'(wr_addr[nw_base + 4]), 256'h0604);
        chk("t6_data4",  256'(wr_data[nw_base + 4]), 256'(expw[4]));
        chk("t6_cen",    256'(out_cen),   256'd1);
        chk("t6_wen",    256'(out_wen),   256'd1);
        chk("t6_addr",   256'(out_addr),  256'd0);
        chk("t6_wdata",  256'(out_wdata), 256'd0);
        chk("t6_busy",   256'(BUSY),      256'd0);
        chk("t6_done",   256'(DONE),      256'd0);
        chk("t6_err",    256'(ERR),       256'd0);
        repeat (2) @(posedge CLK);
        @(negedge CLK) RESET = 1'b1;
        nw_base = nw;
        repeat (25) @(posedge CLK);
        #1;
        chk("t6_no_stale", 256'(nw - nw_base), 256'd0);
        fill_std(16'h3000);
        start_job(13'h0700, 1'b0);
        drive(-1, -1);
        check_job("t6b", 13'h0700);
        chk("t6b_err", 256'(ERR), 256'd0);

        // PSUM_VALID while IDLE
        nw_base = nw;
        PSUM_VALID = 1'b1;
        @(posedge CLK); #1;
        PSUM_VALID = 1'b0;
        repeat (20) @(posedge CLK);
        #1;
        chk("idle_err", 256'(ERR), 256'd1);
        chk("idle_nowr", 256'(nw - nw_base), 256'd0);
        chk("idle_busy", 256'(BUSY), 256'd0);
        chk("bus_consistent", 256'(bus_bad), 256'd0);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
